// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//   APB completer for the 8-bit APB fabric. Decodes a window of NUM_REGS byte
//   registers starting at BASE_ADDR. The top offset (NUM_REGS-1) is a read-only
//   ID register returning ID_VALUE; all lower offsets are read/write. Writes
//   commit on the clock edge that ends the pready cycle. Out-of-window
//   accesses and writes to the ID register complete with pslverr=1.
//
//   Optional feature macro: APB_SLV_WAIT_EN
//     defined   : WAIT state and 4-bit wait counter are built, and WAIT_CYCLES
//                 wait states are inserted before pready.
//     undefined : no wait logic; every transfer completes with zero wait
//                 states whatever WAIT_CYCLES is set to.
//
// Ports
//   clk      in   rising-edge clock
//   resetn   in   synchronous active-low reset
//   psel     in   slave select
//   penable  in   access phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   [ADDR_W] transfer address
//   pwdata   in   [DATA_W] write data
//   prdata   out  [DATA_W] read data, zero unless pready
//   pready   out  transfer complete (one-cycle pulse)
//   pslverr  out  error response, zero unless pready
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
    parameter int unsigned          ADDR_W      = 8,
    parameter int unsigned          DATA_W      = 8,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
    parameter int unsigned          NUM_REGS    = 16,
    parameter logic [DATA_W-1:0]    ID_VALUE    = DATA_W'(8'hA5),
    parameter int unsigned          WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int unsigned       IDX_W  = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0]  ID_IDX = IDX_W'(NUM_REGS - 1);

`ifdef APB_SLV_WAIT_EN
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
`else
    // Wait states compiled out: the parameter is accepted but forced to zero.
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES) & 4'h0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wr_q, wr_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

`ifdef APB_SLV_WAIT_EN
    logic [3:0]          cnt_q, cnt_d;
`endif

    // Setup-phase address decode (modulo ADDR_W subtraction).
    logic [ADDR_W-1:0]   setup_off;
    logic                setup_valid;
    assign setup_off   = paddr - BASE_ADDR;
    assign setup_valid = ({1'b0, setup_off} < (ADDR_W + 1)'(NUM_REGS));

    // Response source: live setup decode when completing straight from IDLE,
    // captured transfer otherwise.
    logic                rsp_en;
    logic [IDX_W-1:0]    rsp_idx;
    logic                rsp_wr;
    logic                rsp_valid;

    // Next-state, capture and registered-response logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        valid_d   = valid_q;
        wdata_d   = wdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        rsp_en    = 1'b0;
        rsp_idx   = idx_q;
        rsp_wr    = wr_q;
        rsp_valid = valid_q;
`ifdef APB_SLV_WAIT_EN
        cnt_d     = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                // psel with penable but no prior setup is ignored.
                if (psel && !penable) begin
                    idx_d     = setup_off[IDX_W-1:0];
                    wr_d      = pwrite;
                    valid_d   = setup_valid;
                    wdata_d   = pwdata;
                    rsp_idx   = setup_off[IDX_W-1:0];
                    rsp_wr    = pwrite;
                    rsp_valid = setup_valid;
                    if (WAIT_LD != 4'd0) begin
`ifdef APB_SLV_WAIT_EN
                        state_d = WAIT;
                        cnt_d   = WAIT_LD;
`endif
                    end else begin
                        state_d = ACCESS;
                        rsp_en  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                state_d = IDLE;
            end
`ifdef APB_SLV_WAIT_EN
            WAIT: begin
                // Master abandoning the transfer wins over the counter.
                cnt_d = cnt_q - 4'd1;
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ACCESS;
                    rsp_en  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rsp_en) begin
            pready_d  = 1'b1;
            pslverr_d = !rsp_valid || (rsp_wr && (rsp_idx == ID_IDX));
            if (!rsp_wr && rsp_valid) begin
                prdata_d = (rsp_idx == ID_IDX) ? ID_VALUE : regs_q[rsp_idx];
            end
        end
    end

    // State, capture, response and register array.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            valid_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            valid_q   <= valid_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= cnt_d;
`endif
            // Commit on the edge that ends the pready cycle.
            if ((state_q == ACCESS) && wr_q && valid_q && (idx_q != ID_IDX)) begin
                regs_q[idx_q] <= wdata_q;
            end
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
//   Directed bench for apb_slave_regfile. dut0: BASE_ADDR=0x10, no wait states.
//   dut1: BASE_ADDR=0x80, WAIT_CYCLES=3 (wait states only when APB_SLV_WAIT_EN
//   is defined). Bus signals are shared; psel selects the target.
// -----------------------------------------------------------------------------
module tb_apb_slave_regfile;

    logic       clk = 1'b0;
    logic       resetn;
    logic       psel0, psel1, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata0, prdata1;
    logic       pready0, pready1, pslverr0, pslverr1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

`ifdef APB_SLV_WAIT_EN
    localparam int EXP_LAT1 = 4;
`else
    localparam int EXP_LAT1 = 1;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_slave_regfile #(
        .ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h10), .NUM_REGS(16),
        .ID_VALUE(8'hA5), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .resetn(resetn), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slave_regfile #(
        .ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h80), .NUM_REGS(16),
        .ID_VALUE(8'hA5), .WAIT_CYCLES(3)
    ) dut1 (
        .clk(clk), .resetn(resetn), .psel(psel1), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? pready0 : pready1;
    endfunction

    task automatic set_sel(input int s, input logic v);
        if (s == 0) psel0 = v;
        else        psel1 = v;
    endtask

    // One APB transfer. b2b=1 drives setup in the current cycle (no gap).
    task automatic xfer(input int s, input logic wr, input logic [7:0] addr,
                        input logic [7:0] data, input logic b2b,
                        output logic [7:0] rd, output logic err,
                        output int lat, output int rcyc);
        if (!b2b) begin
            @(posedge clk); #1;
        end
        set_sel(s, 1'b1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 1;
        while (!rdy(s) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("xfer_ready", 32'(rdy(s)), 32'd1);
        rd   = (s == 0) ? prdata0 : prdata1;
        err  = (s == 0) ? pslverr0 : pslverr1;
        rcyc = cyc;
        @(posedge clk); #1;
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        check_eq("pready_one_cycle", 32'(rdy(s)), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic       err;
        int         lat, rc0, rc1, hits;

        resetn = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pready0",  32'(pready0),  32'd0);
        check_eq("rst_pslverr0", 32'(pslverr0), 32'd0);
        check_eq("rst_prdata0",  32'(prdata0),  32'h0);
        check_eq("rst_pready1",  32'(pready1),  32'd0);
        resetn = 1'b1;

        // Basic write/read, zero wait states
        xfer(0, 1'b1, 8'h10, 8'h55, 1'b0, rd, err, lat, rc0);
        check_eq("wr10_lat", lat, 1);
        check_eq("wr10_err", 32'(err), 32'd0);
        check_eq("wr10_prdata", 32'(rd), 32'h0);
        xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("rd10_data", 32'(rd), 32'h55);
        check_eq("rd10_err", 32'(err), 32'd0);
        check_eq("rd10_lat", lat, 1);

        // ID register
        xfer(0, 1'b0, 8'h1F, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("rd_id_data", 32'(rd), 32'hA5);
        check_eq("rd_id_err", 32'(err), 32'd0);
        xfer(0, 1'b1, 8'h1F, 8'h33, 1'b0, rd, err, lat, rc0);
        check_eq("wr_id_err", 32'(err), 32'd1);
        xfer(0, 1'b0, 8'h1F, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("rd_id_again", 32'(rd), 32'hA5);

        // Out-of-window, above and below the base
        xfer(0, 1'b0, 8'h20, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("rd_oow_err", 32'(err), 32'd1);
        check_eq("rd_oow_data", 32'(rd), 32'h0);
        xfer(0, 1'b1, 8'h20, 8'h77, 1'b0, rd, err, lat, rc0);
        check_eq("wr_oow_err", 32'(err), 32'd1);
        xfer(0, 1'b0, 8'h0F, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("rd_below_err", 32'(err), 32'd1);
        xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("rd10_unchanged", 32'(rd), 32'h55);
        xfer(0, 1'b0, 8'h1E, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("rd1e_zero", 32'(rd), 32'h0);

        // Wait-state slave
        xfer(1, 1'b1, 8'h82, 8'hAA, 1'b0, rd, err, lat, rc0);
        check_eq("w_wr82_lat", lat, EXP_LAT1);
        check_eq("w_wr82_err", 32'(err), 32'd0);
        xfer(1, 1'b0, 8'h82, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("w_rd82_data", 32'(rd), 32'hAA);
        check_eq("w_rd82_lat", lat, EXP_LAT1);

`ifdef APB_SLV_WAIT_EN
        // Abort during WAIT: paddr/pwdata wiggle, then psel drops
        @(posedge clk); #1;
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h83; pwdata = 8'h11;
        @(posedge clk); #1;
        penable = 1'b1; paddr = 8'h84; pwdata = 8'hEE;
        check_eq("abort_wait_rdy", 32'(pready1), 32'd0);
        @(posedge clk); #1;
        psel1 = 1'b0; penable = 1'b0;
        hits = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (pready1) hits++;
        end
        check_eq("abort_no_pready", hits, 0);
        xfer(1, 1'b0, 8'h84, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("abort_rd84", 32'(rd), 32'h0);
`endif
        xfer(1, 1'b0, 8'h83, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("abort_rd83", 32'(rd), 32'h0);

        // Reset during ACCESS of a write
        @(posedge clk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h15; pwdata = 8'h99;
        @(posedge clk); #1;
        penable = 1'b1;
        check_eq("rst_mid_access", 32'(pready0), 32'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_pready", 32'(pready0), 32'd0);
        check_eq("rst_mid_pslverr", 32'(pslverr0), 32'd0);
        resetn = 1'b1; psel0 = 1'b0; penable = 1'b0;
        xfer(0, 1'b0, 8'h15, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("rst_rd15", 32'(rd), 32'h0);
        xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("rst_rd10_cleared", 32'(rd), 32'h0);

        // Back-to-back reads (write then read same register too)
        xfer(0, 1'b1, 8'h11, 8'h21, 1'b0, rd, err, lat, rc0);
        xfer(0, 1'b1, 8'h12, 8'h42, 1'b0, rd, err, lat, rc0);
        xfer(0, 1'b0, 8'h11, 8'h00, 1'b0, rd, err, lat, rc0);
        check_eq("b2b_rd11", 32'(rd), 32'h21);
        xfer(0, 1'b0, 8'h12, 8'h00, 1'b1, rd, err, lat, rc1);
        check_eq("b2b_rd12", 32'(rd), 32'h42);
        check_eq("b2b_gap", rc1 - rc0, 2);
        xfer(0, 1'b1, 8'h13, 8'h6C, 1'b0, rd, err, lat, rc0);
        xfer(0, 1'b0, 8'h13, 8'h00, 1'b1, rd, err, lat, rc1);
        check_eq("b2b_wr_rd13", 32'(rd), 32'h6C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
